// File: rtl/qeciphy_link_supervisor.sv
// Link recovery sequencer: requests PHY reset sequences, supervises bring-up and error rate,
// retries with exponential backoff and latches FAILED once the retry budget is spent.
//
// state         | meaning
// IDLE          | supervision disabled
// RST_ASSERT    | reset request held high
// WAIT_RST_DONE | waiting for reset controller completion
// WAIT_LINK     | waiting for link-up
// LINK_UP       | link healthy, errors counted per window
// BACKOFF       | delay before re-issuing reset
// FAILED        | retries exhausted, holding
module qeciphy_link_supervisor #(
    parameter int unsigned RST_PULSE_CYCLES = 16,
    parameter int unsigned LINK_TIMEOUT     = 65535,
    parameter int unsigned ERR_THRESHOLD    = 8,
    parameter int unsigned ERR_WINDOW       = 1024,
    parameter int unsigned MAX_RETRIES      = 7,
    parameter int unsigned BACKOFF_BASE     = 256
) (
    input  logic       axis_clk_i,
    input  logic       axis_rst_i,
    input  logic       enable_i,
    input  logic       sw_reset_req_i,
    input  logic       rst_done_i,
    input  logic       link_up_i,
    input  logic       err_pulse_i,
    output logic       rst_req_o,
    output logic       link_ok_o,
    output logic       failed_o,
    output logic [3:0] retry_count_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        RST_ASSERT    = 3'd1,
        WAIT_RST_DONE = 3'd2,
        WAIT_LINK     = 3'd3,
        LINK_UP       = 3'd4,
        BACKOFF       = 3'd5,
        FAILED        = 3'd6
    } state_t;

    // The shared timer counts down; loading N-1 on entry keeps a state for exactly N cycles.
    localparam logic [15:0] PULSE_LOAD   = 16'(RST_PULSE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LOAD = 16'(LINK_TIMEOUT - 1);
    localparam logic [15:0] WINDOW_LOAD  = 16'(ERR_WINDOW - 1);
    localparam logic [15:0] BACKOFF_UNIT = 16'(BACKOFF_BASE);
    localparam logic [8:0]  ERR_LIMIT    = 9'(ERR_THRESHOLD);
    localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  retry_q, retry_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        rst_req_q, link_ok_q, failed_q;
    logic        retry_ev;
    logic        err_trip;
    logic [15:0] backoff_load;

    assign backoff_load = (BACKOFF_UNIT << retry_q) - 16'd1;
    assign err_trip     = err_pulse_i && (({1'b0, err_cnt_q} + 9'd1) >= ERR_LIMIT);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        retry_d   = retry_q;
        err_cnt_d = err_cnt_q;
        retry_ev  = 1'b0;

        if (!enable_i) begin
            state_d   = IDLE;
            retry_d   = 4'd0;
            err_cnt_d = 8'd0;
        end else if (sw_reset_req_i && (state_q != IDLE)) begin
            state_d = RST_ASSERT;
            timer_d = PULSE_LOAD;
            retry_d = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = RST_ASSERT;
                    timer_d = PULSE_LOAD;
                end
                RST_ASSERT: begin
                    if (timer_q == 16'd0) begin
                        state_d = WAIT_RST_DONE;
                        timer_d = TIMEOUT_LOAD;
                    end else begin
                        timer_d = timer_q - 16'd1;
                    end
                end
                WAIT_RST_DONE: begin
                    if (rst_done_i) begin
                        state_d = WAIT_LINK;
                        timer_d = TIMEOUT_LOAD;
                    end else if (timer_q == 16'd0) begin
                        retry_ev = 1'b1;
                    end else begin
                        timer_d = timer_q - 16'd1;
                    end
                end
                WAIT_LINK: begin
                    if (link_up_i) begin
                        state_d   = LINK_UP;
                        timer_d   = WINDOW_LOAD;
                        err_cnt_d = 8'd0;
                    end else if (timer_q == 16'd0) begin
                        retry_ev = 1'b1;
                    end else begin
                        timer_d = timer_q - 16'd1;
                    end
                end
                LINK_UP: begin
                    if (!link_up_i || err_trip) begin
                        retry_ev = 1'b1;
                    end else if (timer_q == 16'd0) begin
                        // A full clean window forgives earlier retries.
                        timer_d   = WINDOW_LOAD;
                        err_cnt_d = 8'd0;
                        retry_d   = 4'd0;
                    end else begin
                        timer_d = timer_q - 16'd1;
                        if (err_pulse_i && (err_cnt_q != 8'hFF)) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end
                end
                BACKOFF: begin
                    if (timer_q == 16'd0) begin
                        state_d = RST_ASSERT;
                        timer_d = PULSE_LOAD;
                    end else begin
                        timer_d = timer_q - 16'd1;
                    end
                end
                FAILED: begin
                    state_d = FAILED;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (retry_ev) begin
                if (retry_q == RETRY_LIMIT) begin
                    state_d = FAILED;
                end else begin
                    state_d = BACKOFF;
                    timer_d = backoff_load;
                    retry_d = retry_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge axis_clk_i) begin
        if (axis_rst_i) begin
            state_q   <= IDLE;
            timer_q   <= 16'd0;
            retry_q   <= 4'd0;
            err_cnt_q <= 8'd0;
            rst_req_q <= 1'b0;
            link_ok_q <= 1'b0;
            failed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            err_cnt_q <= err_cnt_d;
            rst_req_q <= (state_d == RST_ASSERT);
            link_ok_q <= (state_d == LINK_UP);
            failed_q  <= (state_d == FAILED);
        end
    end

    assign rst_req_o     = rst_req_q;
    assign link_ok_o     = link_ok_q;
    assign failed_o      = failed_q;
    assign retry_count_o = retry_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_qeciphy_link_supervisor.sv
// Bench for qeciphy_link_supervisor: directed scenarios with fixed expectations, then
// randomized stimulus compared every cycle against an elapsed-time behavioural model.
module tb_qeciphy_link_supervisor;

    localparam int P  = 4;
    localparam int T  = 100;
    localparam int E  = 3;
    localparam int W  = 50;
    localparam int MR = 2;
    localparam int BB = 8;

    localparam int S_IDLE = 0;
    localparam int S_RST  = 1;
    localparam int S_WRD  = 2;
    localparam int S_WL   = 3;
    localparam int S_LU   = 4;
    localparam int S_BO   = 5;
    localparam int S_FAIL = 6;

    logic       clk = 1'b0;
    logic       axis_rst = 1'b1;
    logic       enable = 1'b0;
    logic       sw_req = 1'b0;
    logic       rst_done = 1'b0;
    logic       link_up = 1'b0;
    logic       err_pulse = 1'b0;
    logic       rst_req_o, link_ok_o, failed_o;
    logic [3:0] retry_o;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_pass   = 0;
    int hi_run = 0, last_pulse = 0, pulse_total = 0;

    // model: state, cycles spent in state (entry = 1), retries, errors, window cycle, backoff length
    int m_st = 0, m_age = 0, m_retry = 0, m_errs = 0, m_win = 0, m_bo = 0;

    int done_opts[3] = '{0, 15, 80};
    int up_opts[2]   = '{10, 60};
    int drop_opts[3] = '{0, 2, 8};
    int err_opts[3]  = '{0, 15, 45};
    int p_done, p_up, p_drop, p_err;
    bit up_lvl = 1'b0;
    int n;

    always #5 clk = ~clk;

    qeciphy_link_supervisor #(
        .RST_PULSE_CYCLES(P),
        .LINK_TIMEOUT    (T),
        .ERR_THRESHOLD   (E),
        .ERR_WINDOW      (W),
        .MAX_RETRIES     (MR),
        .BACKOFF_BASE    (BB)
    ) dut (
        .axis_clk_i    (clk),
        .axis_rst_i    (axis_rst),
        .enable_i      (enable),
        .sw_reset_req_i(sw_req),
        .rst_done_i    (rst_done),
        .link_up_i     (link_up),
        .err_pulse_i   (err_pulse),
        .rst_req_o     (rst_req_o),
        .link_ok_o     (link_ok_o),
        .failed_o      (failed_o),
        .retry_count_o (retry_o),
        .state_o       (state_o)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
    endtask

    function automatic void model_step(input bit rst, input bit en, input bit sw,
                                       input bit done, input bit up, input bit err);
        int ns;
        bit enter;
        bit retry_ev;
        ns       = m_st;
        enter    = 1'b0;
        retry_ev = 1'b0;
        if (rst) begin
            m_st = S_IDLE; m_age = 0; m_retry = 0; m_errs = 0; m_win = 0; m_bo = 0;
            return;
        end
        if (!en) begin
            ns = S_IDLE; m_retry = 0; m_errs = 0;
        end else if (sw && m_st != S_IDLE) begin
            ns = S_RST; m_retry = 0; enter = 1'b1;
        end else begin
            case (m_st)
                S_IDLE: ns = S_RST;
                S_RST:  if (m_age == P) ns = S_WRD;
                S_WRD: begin
                    if (done) ns = S_WL;
                    else if (m_age == T) retry_ev = 1'b1;
                end
                S_WL: begin
                    if (up) begin ns = S_LU; m_errs = 0; m_win = 1; end
                    else if (m_age == T) retry_ev = 1'b1;
                end
                S_LU: begin
                    if (!up) retry_ev = 1'b1;
                    else if (err && (m_errs + 1 >= E)) retry_ev = 1'b1;
                    else if (m_win == W) begin m_errs = 0; m_retry = 0; m_win = 1; end
                    else begin
                        if (err && m_errs < 255) m_errs++;
                        m_win++;
                    end
                end
                S_BO:   if (m_age == m_bo) ns = S_RST;
                default: ;
            endcase
            if (retry_ev) begin
                if (m_retry == MR) ns = S_FAIL;
                else begin
                    m_bo = BB * (2 ** m_retry);
                    m_retry++;
                    ns = S_BO;
                end
            end
        end
        if (ns != m_st) enter = 1'b1;
        m_age = enter ? 1 : m_age + 1;
        m_st  = ns;
    endfunction

    task automatic compare_all();
        check_val("state",   32'(state_o),   32'(m_st));
        check_val("rst_req", 32'(rst_req_o), 32'(m_st == S_RST));
        check_val("link_ok", 32'(link_ok_o), 32'(m_st == S_LU));
        check_val("failed",  32'(failed_o),  32'(m_st == S_FAIL));
        check_val("retry",   32'(retry_o),   32'(m_retry));
        if (rst_req_o === 1'b1) begin
            hi_run++;
            pulse_total++;
        end else begin
            if (hi_run != 0) last_pulse = hi_run;
            hi_run = 0;
        end
    endtask

    task automatic tick(input bit rst, input bit en, input bit sw,
                        input bit done, input bit up, input bit err);
        axis_rst = rst; enable = en; sw_req = sw; rst_done = done; link_up = up; err_pulse = err;
        model_step(rst, en, sw, done, up, err);
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input int cycles, input bit done, input bit up);
        for (int i = 0; i < cycles; i++) tick(1'b0, 1'b1, 1'b0, done, up, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        check_val("reset_state",  32'(state_o), 32'd0);
        check_val("reset_rstreq", 32'(rst_req_o), 32'd0);
        check_val("reset_retry",  32'(retry_o), 32'd0);

        // clean bring-up
        tick(0, 1, 0, 0, 0, 0);
        check_val("up_rst_assert", 32'(state_o), 32'd1);
        run(4, 0, 0);
        check_val("up_pulse_len", 32'(last_pulse), 32'd4);
        check_val("up_wait_done", 32'(state_o), 32'd2);
        run(9, 0, 0);
        tick(0, 1, 0, 1, 0, 0);
        check_val("up_wait_link", 32'(state_o), 32'd3);
        run(4, 0, 0);
        tick(0, 1, 0, 0, 1, 0);
        check_val("up_link_up", 32'(state_o), 32'd4);
        check_val("up_link_ok", 32'(link_ok_o), 32'd1);
        check_val("up_retry0",  32'(retry_o), 32'd0);

        // error threshold
        tick(0, 1, 0, 0, 1, 1);
        run(3, 0, 1);
        tick(0, 1, 0, 0, 1, 1);
        run(3, 0, 1);
        tick(0, 1, 0, 0, 1, 1);
        check_val("thr_backoff", 32'(state_o), 32'd5);
        check_val("thr_retry1",  32'(retry_o), 32'd1);
        n = 0;
        while (state_o == 3'd5 && n < 40) begin
            tick(0, 1, 0, 0, 1, 0);
            n++;
        end
        check_val("thr_backoff_len", 32'(n), 32'd8);
        run(4, 0, 1);
        check_val("thr_pulse_len", 32'(last_pulse), 32'd4);
        tick(0, 1, 0, 1, 1, 0);
        tick(0, 1, 0, 0, 1, 0);
        check_val("win_link_up", 32'(state_o), 32'd4);
        for (int i = 1; i <= 49; i++) tick(0, 1, 0, 0, 1, (i == 10 || i == 30));
        check_val("win_retry_held", 32'(retry_o), 32'd1);
        tick(0, 1, 0, 0, 1, 0);
        check_val("win_retry_clr", 32'(retry_o), 32'd0);
        for (int i = 1; i <= 50; i++) tick(0, 1, 0, 0, 1, (i == 5 || i == 45));
        check_val("win_stays_up", 32'(state_o), 32'd4);

        // link drop
        tick(0, 1, 0, 0, 0, 0);
        check_val("drop_state",   32'(state_o), 32'd5);
        check_val("drop_link_ok", 32'(link_ok_o), 32'd0);

        // timeout chain to FAILED
        tick(1, 0, 0, 0, 0, 0);
        pulse_total = 0;
        tick(0, 1, 0, 0, 0, 0);
        n = 0;
        while (state_o != 3'd6 && n < 1000) begin
            tick(0, 1, 0, 0, 0, 0);
            n++;
        end
        check_val("fail_time",   32'(n), 32'd336);
        check_val("fail_pulses", 32'(pulse_total), 32'd12);
        check_val("fail_flag",   32'(failed_o), 32'd1);
        check_val("fail_retry",  32'(retry_o), 32'd2);
        run(20, 0, 0);
        check_val("fail_hold",   32'(state_o), 32'd6);
        check_val("fail_rstreq", 32'(rst_req_o), 32'd0);

        // software recovery
        tick(0, 1, 1, 0, 0, 0);
        check_val("sw_failed", 32'(failed_o), 32'd0);
        check_val("sw_retry",  32'(retry_o), 32'd0);
        run(4, 0, 0);
        check_val("sw_pulse_len", 32'(last_pulse), 32'd4);

        // disable mid-pulse, then reset in WAIT_LINK
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        check_val("dis_rstreq", 32'(rst_req_o), 32'd0);
        check_val("dis_state",  32'(state_o), 32'd0);
        tick(0, 1, 0, 0, 0, 0);
        run(4, 0, 0);
        tick(0, 1, 0, 1, 0, 0);
        check_val("rst_in_wl_pre", 32'(state_o), 32'd3);
        tick(1, 1, 0, 0, 0, 0);
        check_val("rst_in_wl_outs", 32'({state_o, retry_o, rst_req_o, link_ok_o, failed_o}), 32'd0);

        // simultaneous events
        tick(0, 1, 0, 0, 0, 0);
        run(4, 0, 0);
        tick(0, 1, 0, 1, 0, 0);
        tick(0, 1, 0, 0, 1, 0);
        tick(0, 1, 0, 0, 1, 1);
        tick(0, 1, 0, 0, 1, 1);
        tick(0, 1, 0, 0, 0, 1);
        check_val("drop_thr_state", 32'(state_o), 32'd5);
        check_val("drop_thr_retry", 32'(retry_o), 32'd1);
        run(8, 0, 0);
        run(4, 0, 0);
        run(99, 0, 0);
        tick(0, 1, 1, 0, 0, 0);
        check_val("sw_retry_state", 32'(state_o), 32'd1);
        check_val("sw_retry_cnt",   32'(retry_o), 32'd0);
        tick(0, 0, 1, 0, 0, 0);
        check_val("dis_sw_state", 32'(state_o), 32'd0);

        // randomized traffic
        tick(1, 0, 0, 0, 0, 0);
        for (int blk = 0; blk < 24; blk++) begin
            p_done = done_opts[$urandom_range(0, 2)];
            p_up   = up_opts[$urandom_range(0, 1)];
            p_drop = drop_opts[$urandom_range(0, 2)];
            p_err  = err_opts[$urandom_range(0, 2)];
            for (int c = 0; c < 250; c++) begin
                bit r, e, s, d, er;
                r = ($urandom_range(0, 2999) == 0);
                e = ($urandom_range(0, 399) != 0);
                s = (m_st == S_FAIL) ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 499) == 0);
                d = ($urandom_range(0, 999) < p_done);
                if (up_lvl) up_lvl = !($urandom_range(0, 999) < p_drop);
                else        up_lvl = ($urandom_range(0, 999) < p_up);
                er = ($urandom_range(0, 999) < p_err);
                tick(r, e, s, d, up_lvl, er);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
